// File: rtl/core_mc_sequencer_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } core_state_e;

  localparam int          PC_STEP              = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/core_mc_sequencer_mem_wait_timer.sv
// Counts consecutive wait cycles of an outstanding memory request and flags
// expiry on the last allowed cycle, unless the response arrives in that cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  input  logic valid,
  output logic expired
);

  localparam int             CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;
  logic          at_last_s;

  assign at_last_s = (count_r == LAST);
  assign expired   = waiting && !valid && at_last_s;

  // Wait-cycle counter; saturates at LAST since expiry leaves the wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (waiting && !valid && !at_last_s) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/core_mc_sequencer.sv
// Multi-cycle control sequencer: owns PC, IR and retired counter, walks each
// instruction through FETCH/DECODE/EXEC/[MEM]/WB with halt and timeout faults.
module core_mc_sequencer
  import core_pkg::*;
#(
  parameter int                 ADDRESS      = 32,
  parameter int                 INSTRUCTION  = 32,
  parameter logic [ADDRESS-1:0] RESET_VECTOR = ADDRESS'(DEFAULT_RESET_VECTOR),
  parameter int                 TIMEOUT      = 16,
  parameter int                 CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTRUCTION-1:0] instruction,
  input  logic                   instruction_mem_valid,
  input  logic                   DM_valid,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic                   pc_sel,
  input  logic [ADDRESS-1:0]     pc_target,
  input  logic                   halt_req,
  output logic [ADDRESS-1:0]     pc_addr_out,
  output logic [INSTRUCTION-1:0] instruction_out,
  output logic                   instruction_mem_request,
  output logic                   data_mem_request,
  output logic                   data_mem_we_re,
  output logic                   rf_we,
  output logic [2:0]             state_out,
  output logic                   halted,
  output logic                   fault,
  output logic [CNT_W-1:0]       retired_count
);

  localparam logic [ADDRESS-1:0] ALIGN_MASK = {{(ADDRESS-2){1'b1}}, 2'b00};

  core_state_e            state_r;
  logic [ADDRESS-1:0]     pc_r;
  logic [INSTRUCTION-1:0] ir_r;
  logic [CNT_W-1:0]       retired_r;
  logic                   fault_r;
  logic                   halted_r;

  logic                   waiting_s;
  logic                   wait_valid_s;
  logic                   expired_s;
  logic [ADDRESS-1:0]     pc_next_s;

  // One timer serves both FETCH and MEM; it is held clear in every other state.
  assign waiting_s    = (state_r == FETCH) || (state_r == MEM);
  assign wait_valid_s = (state_r == FETCH) ? instruction_mem_valid : DM_valid;
  assign pc_next_s    = pc_sel ? (pc_target & ALIGN_MASK) : (pc_r + ADDRESS'(PC_STEP));

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting_s),
    .waiting (waiting_s),
    .valid   (wait_valid_s),
    .expired (expired_s)
  );

  // Sequencer state, PC, IR, retire counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH;
      pc_r      <= RESET_VECTOR;
      ir_r      <= '0;
      retired_r <= '0;
      fault_r   <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (instruction_mem_valid) begin
            ir_r    <= instruction;
            state_r <= DECODE;
          end else if (expired_s) begin
            fault_r <= 1'b1;
            state_r <= FAULT;
          end else begin
            state_r <= FETCH;
          end
        end
        DECODE: state_r <= EXEC;
        EXEC:   state_r <= (is_load || is_store) ? MEM : WB;
        MEM: begin
          if (DM_valid) begin
            state_r <= WB;
          end else if (expired_s) begin
            fault_r <= 1'b1;
            state_r <= FAULT;
          end else begin
            state_r <= MEM;
          end
        end
        WB: begin
          pc_r      <= pc_next_s;
          retired_r <= retired_r + CNT_W'(1);
          halted_r  <= halt_req;
          state_r   <= halt_req ? HALT : FETCH;
        end
        HALT:  state_r <= HALT;
        FAULT: state_r <= FAULT;
        default: begin
          // An unreachable encoding is treated as a fault rather than recovered.
          fault_r <= 1'b1;
          state_r <= FAULT;
        end
      endcase
    end
  end

  // Request and strobe decode from the current state.
  always_comb begin
    instruction_mem_request = 1'b0;
    data_mem_request        = 1'b0;
    data_mem_we_re          = 1'b0;
    rf_we                   = 1'b0;
    case (state_r)
      FETCH: instruction_mem_request = 1'b1;
      MEM: begin
        data_mem_request = 1'b1;
        data_mem_we_re   = is_store;
      end
      WB:      rf_we = !is_store;
      default: rf_we = 1'b0;
    endcase
  end

  assign pc_addr_out     = pc_r;
  assign instruction_out = ir_r;
  assign state_out       = state_r;
  assign halted          = halted_r;
  assign fault           = fault_r;
  assign retired_count   = retired_r;

endmodule
